remote_load_latency_monitor: RTL and testbench
==============================================

Name: remote_load_latency_monitor

Overview:
- Synthesizable, parametrised successor to the per-core remote-load tracer; sits beside the vanilla core's network_tx.
- Timestamps each outstanding remote load: int (incl. AMO), float, icache.
- On each accepted response, computes latency and accumulates per-type statistics: count, sum, min, max, and an optional latency histogram.
- Statistics are read back through a registered read port, so they are usable on FPGA/emulation where $fwrite is not available.

Parameters:
- reg_els_p, 32, number of int/float destination register slots tracked per type
- ctr_width_p, 32, width of global_ctr_i and of all latency values
- stat_width_p, 32, width of every statistic register (count/sum/min/max/bin)
- num_bins_p, 8, histogram bins per type (power of 2, ≥2)
- bin_shift_p, 3, bin index = latency >> bin_shift_p, clamped to num_bins_p-1
- reg_id_width_lp, `BSG_SAFE_CLOG2(reg_els_p), derived
- rd_addr_width_lp, 2+`BSG_SAFE_CLOG2(4+num_bins_p), derived

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- launch_v_i  in  1  remote load leaves the core this cycle
- launch_type_i  in  2  0=int, 1=float, 2=icache; 3 is ignored
- launch_reg_id_i  in  reg_id_width_lp  destination register (ignored for icache)
- return_v_i  in  1  response valid
- return_yumi_i  in  1  response accepted by the core; an event is return_v_i & return_yumi_i
- return_type_i  in  2  same encoding as launch_type_i
- return_reg_id_i  in  reg_id_width_lp  register of the response
- global_ctr_i  in  ctr_width_p  free-running cycle counter
- stat_en_i  in  1  statistics update enable
- clear_i  in  1  synchronous clear of statistics and sticky flags
- rd_v_i  in  1  read request
- rd_addr_i  in  rd_addr_width_lp  {type[1:0], field}; field 0=count, 1=sum, 2=min, 3=max, 4+k=bin k
- rd_data_o  out  stat_width_p  read data, one cycle after rd_v_i
- outstanding_o  out  `BSG_SAFE_CLOG2(2*reg_els_p+2)  number of valid pending entries
- orphan_o  out  1  sticky: a return matched no valid pending entry
- dup_o  out  1  sticky: a launch hit an already-valid slot

Behaviour:
- Reset (async): all pending valids 0; count/sum/max and bins 0; min all-ones; rd_data_o 0; outstanding_o 0; orphan_o 0; dup_o 0.
- Pending table: int[reg_els_p], float[reg_els_p], icache[1]. Each entry holds {valid, start}.
- Launch: sets valid and start=global_ctr_i on the next edge. If the slot is already valid, the entry is overwritten and dup_o is set.
- Return event on a valid entry:
  - latency = global_ctr_i - start, modulo 2^ctr_width_p, so counter wrap is handled.
  - Entry valid is cleared.
  - If stat_en_i: count+=1; sum+=latency; min/max updated; bin[min(latency>>bin_shift_p, num_bins_p-1)]+=1. All of these saturate at all-ones.
  - Stats are visible to a read issued the following cycle.
- Return event on an invalid entry: orphan_o is set; no stat change.
- Launch and return on the same slot in the same cycle: the return uses the old start; the new start is written; valid stays 1; dup_o is not set.
- Launch and return on different slots in the same cycle: both are handled independently.
- Type 3 on launch or return: no effect.
- stat_en_i low: pending table still maintained, stats frozen.
- clear_i: resets stats, orphan_o, and dup_o to their reset values. The pending table is untouched. clear_i has priority over a same-cycle stat update.
- Read: rd_data_o registered on the edge after rd_v_i, and holds until the next rd_v_i. Fields that are out of range or belong to type 3 read 0.
- outstanding_o: registered popcount of the pending valids.

Optional Feature:
- REMOTE_LOAD_MONITOR_HISTOGRAM_EN defined: bin registers and bin logic are built.
- Undefined: no bin storage; bin fields read 0; count/sum/min/max unchanged.

Decomposition:
- Package remote_load_monitor_pkg:
  - rlm_type_e (e_rlm_int, e_rlm_float, e_rlm_icache)
  - field constants (e_rlm_count, e_rlm_sum, e_rlm_min, e_rlm_max, e_rlm_bin_base)
  - rlm_pending_s {valid, start}
- Sub-module remote_load_stat_accum: one instance per type. It holds count/sum/min/max/bins with saturation, clear, and a read mux.

Test Plan:
- Async reset mid-operation with 3 loads pending → outstanding_o=0 immediately; stats cleared; min reads 0xFFFFFFFF.
- Int launch reg 5 at ctr 100; return at ctr 137 → int count=1, sum=37, min=max=37; bin[4]=1 (shift 3).
- Float launch at ctr 0xFFFFFFF0; return at ctr 0x10 → latency 32; float bin[4]=1; int stats unchanged.
- Icache launch at ctr 10; same-cycle return of int reg 5 and relaunch of reg 5 at ctr 50 → int latency recorded against the old start; outstanding_o stays 2; dup_o=0.
- Return of int reg 9 never launched → orphan_o=1, count unchanged. Then clear_i → orphan_o=0, count=0.
- Latency 1000 with num_bins_p=8 → bin[7]=1. Force count to all-ones and return again → count stays all-ones. Without the macro, bin reads return 0.

Source files
------------

// File: rtl/remote_load_monitor_pkg.sv
// Shared types and helpers for the remote-load latency monitor.
package remote_load_monitor_pkg;

  typedef enum logic [1:0] {
    e_rlm_int    = 2'd0,
    e_rlm_float  = 2'd1,
    e_rlm_icache = 2'd2
  } rlm_type_e;

  localparam int e_rlm_count    = 0;
  localparam int e_rlm_sum      = 1;
  localparam int e_rlm_min      = 2;
  localparam int e_rlm_max      = 3;
  localparam int e_rlm_bin_base = 4;

  // Start stamps are stored at the widest supported counter width; unused upper bits are trimmed.
  localparam int rlm_start_width_lp = 64;

  typedef struct packed {
    logic                          valid;
    logic [rlm_start_width_lp-1:0] start;
  } rlm_pending_s;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/remote_load_stat_accum.sv
// Per-type latency statistics: saturating count/sum/min/max, histogram when
// REMOTE_LOAD_MONITOR_HISTOGRAM_EN is defined, synchronous clear and a field read mux.
module remote_load_stat_accum
  import remote_load_monitor_pkg::*;
#(
  parameter int ctr_width_p    = 32,
  parameter int stat_width_p   = 32,
  parameter int num_bins_p     = 8,
  parameter int bin_shift_p    = 3,
  parameter int field_width_lp = safe_clog2(4 + num_bins_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      clear_i,
  input  logic                      upd_i,
  input  logic [ctr_width_p-1:0]    lat_i,
  input  logic [field_width_lp-1:0] field_i,
  output logic [stat_width_p-1:0]   data_o
);

  localparam int ew_lp = ((ctr_width_p > stat_width_p) ? ctr_width_p : stat_width_p) + 1;
  localparam logic [stat_width_p-1:0] ones_lp = '1;

  logic [ew_lp-1:0]        lat_ext, sum_ext;
  logic [stat_width_p-1:0] lat_sat;
  logic [stat_width_p-1:0] count_q, count_d, sum_q, sum_d, min_q, min_d, max_q, max_d;
  logic [stat_width_p-1:0] bin_rd;
  logic [31:0]             fld;

  assign fld = 32'(field_i);

  always_comb begin
    lat_ext = ew_lp'(lat_i);
    lat_sat = (lat_ext > ew_lp'(ones_lp)) ? ones_lp : lat_ext[stat_width_p-1:0];
    sum_ext = ew_lp'(sum_q) + lat_ext;
    count_d = count_q;
    sum_d   = sum_q;
    min_d   = min_q;
    max_d   = max_q;
    if (clear_i) begin
      count_d = '0;
      sum_d   = '0;
      min_d   = ones_lp;
      max_d   = '0;
    end else if (upd_i) begin
      count_d = (count_q == ones_lp) ? count_q : count_q + stat_width_p'(1);
      sum_d   = (sum_ext > ew_lp'(ones_lp)) ? ones_lp : sum_ext[stat_width_p-1:0];
      if (lat_sat < min_q) min_d = lat_sat;
      if (lat_sat > max_q) max_d = lat_sat;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
      sum_q   <= '0;
      min_q   <= ones_lp;
      max_q   <= '0;
    end else begin
      count_q <= count_d;
      sum_q   <= sum_d;
      min_q   <= min_d;
      max_q   <= max_d;
    end
  end

`ifdef REMOTE_LOAD_MONITOR_HISTOGRAM_EN
  localparam int bin_w_lp = safe_clog2(num_bins_p);

  logic [ctr_width_p-1:0]                  lat_shift;
  logic [bin_w_lp-1:0]                     bin_idx, bin_sel;
  logic [num_bins_p-1:0][stat_width_p-1:0] bin_q, bin_d;

  always_comb begin
    lat_shift = lat_i >> bin_shift_p;
    bin_idx   = (lat_shift > ctr_width_p'(num_bins_p - 1)) ? bin_w_lp'(num_bins_p - 1)
                                                          : lat_shift[bin_w_lp-1:0];
    bin_d = bin_q;
    if (clear_i) bin_d = '0;
    else if (upd_i && bin_q[bin_idx] != ones_lp) bin_d[bin_idx] = bin_q[bin_idx] + stat_width_p'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) bin_q <= '0;
    else         bin_q <= bin_d;
  end

  assign bin_sel = bin_w_lp'(fld - 32'(e_rlm_bin_base));
  assign bin_rd  = bin_q[bin_sel];
`else
  assign bin_rd = '0;
`endif

  always_comb begin
    data_o = '0;
    if      (fld == 32'(e_rlm_count)) data_o = count_q;
    else if (fld == 32'(e_rlm_sum))   data_o = sum_q;
    else if (fld == 32'(e_rlm_min))   data_o = min_q;
    else if (fld == 32'(e_rlm_max))   data_o = max_q;
    else if (fld < 32'(e_rlm_bin_base + num_bins_p)) data_o = bin_rd;
  end

endmodule

// File: rtl/remote_load_latency_monitor.sv
// Remote-load latency monitor: pending-load table plus per-type statistics with a registered
// read port. Histogram bins are built only when REMOTE_LOAD_MONITOR_HISTOGRAM_EN is defined.
module remote_load_latency_monitor
  import remote_load_monitor_pkg::*;
#(
  parameter int reg_els_p        = 32,
  parameter int ctr_width_p      = 32,
  parameter int stat_width_p     = 32,
  parameter int num_bins_p       = 8,
  parameter int bin_shift_p      = 3,
  parameter int reg_id_width_lp  = safe_clog2(reg_els_p),
  parameter int rd_addr_width_lp = 2 + safe_clog2(4 + num_bins_p)
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  input  logic                                        launch_v_i,
  input  logic [1:0]                                  launch_type_i,
  input  logic [reg_id_width_lp-1:0]                  launch_reg_id_i,
  input  logic                                        return_v_i,
  input  logic                                        return_yumi_i,
  input  logic [1:0]                                  return_type_i,
  input  logic [reg_id_width_lp-1:0]                  return_reg_id_i,
  input  logic [ctr_width_p-1:0]                      global_ctr_i,
  input  logic                                        stat_en_i,
  input  logic                                        clear_i,
  input  logic                                        rd_v_i,
  input  logic [rd_addr_width_lp-1:0]                 rd_addr_i,
  output logic [stat_width_p-1:0]                     rd_data_o,
  output logic [safe_clog2(2*reg_els_p+2)-1:0]        outstanding_o,
  output logic                                        orphan_o,
  output logic                                        dup_o
);

  localparam int slots_lp   = 2 * reg_els_p + 1;
  localparam int slot_w_lp  = safe_clog2(slots_lp);
  localparam int out_w_lp   = safe_clog2(2 * reg_els_p + 2);
  localparam int field_w_lp = rd_addr_width_lp - 2;

  rlm_pending_s [slots_lp-1:0]     pend_q, pend_d;
  logic [slot_w_lp-1:0]            l_idx, r_idx;
  logic                            l_ok, r_ok, l_en, r_en, ret_hit;
  logic [ctr_width_p-1:0]          lat;
  logic [out_w_lp-1:0]             outstanding_q, outstanding_d;
  logic                            orphan_q, orphan_d, dup_q, dup_d;
  logic [stat_width_p-1:0]         rd_data_q, rd_data_d;
  logic [3:0][stat_width_p-1:0]    acc_rd;
  logic [2:0]                      upd;
  logic [1:0]                      rd_type;

  // Table layout: int slots, then float slots, then the single icache slot.
  function automatic logic [slot_w_lp:0] slot_of(input logic [1:0] t,
                                                 input logic [reg_id_width_lp-1:0] id);
    logic id_ok;
    id_ok = 32'(id) < 32'(reg_els_p);
    case (t)
      e_rlm_int:    slot_of = {id_ok, slot_w_lp'(id)};
      e_rlm_float:  slot_of = {id_ok, slot_w_lp'(reg_els_p) + slot_w_lp'(id)};
      e_rlm_icache: slot_of = {1'b1, slot_w_lp'(2 * reg_els_p)};
      default:      slot_of = '0;
    endcase
  endfunction

  always_comb begin
    {l_ok, l_idx} = slot_of(launch_type_i, launch_reg_id_i);
    {r_ok, r_idx} = slot_of(return_type_i, return_reg_id_i);
    l_en    = l_ok & launch_v_i;
    r_en    = r_ok & return_v_i & return_yumi_i;
    ret_hit = r_en & pend_q[r_idx].valid;
    lat     = global_ctr_i - pend_q[r_idx].start[ctr_width_p-1:0];

    pend_d   = pend_q;
    orphan_d = orphan_q;
    dup_d    = dup_q;
    if (r_en) begin
      if (pend_q[r_idx].valid) pend_d[r_idx].valid = 1'b0;
      else                     orphan_d = 1'b1;
    end
    // Launch is applied after the return so a same-slot relaunch leaves the entry valid.
    if (l_en) begin
      if (pend_q[l_idx].valid && !(ret_hit && r_idx == l_idx)) dup_d = 1'b1;
      pend_d[l_idx].valid = 1'b1;
      pend_d[l_idx].start = rlm_start_width_lp'(global_ctr_i);
    end
    if (clear_i) begin
      orphan_d = 1'b0;
      dup_d    = 1'b0;
    end

    outstanding_d = '0;
    for (int i = 0; i < slots_lp; i++) outstanding_d = outstanding_d + out_w_lp'(pend_d[i].valid);

    for (int t = 0; t < 3; t++) upd[t] = ret_hit & stat_en_i & (return_type_i == 2'(t));

    rd_type   = rd_addr_i[rd_addr_width_lp-1 -: 2];
    rd_data_d = rd_v_i ? acc_rd[rd_type] : rd_data_q;
  end

  for (genvar t = 0; t < 3; t++) begin : g_acc
    remote_load_stat_accum #(
      .ctr_width_p   (ctr_width_p),
      .stat_width_p  (stat_width_p),
      .num_bins_p    (num_bins_p),
      .bin_shift_p   (bin_shift_p),
      .field_width_lp(field_w_lp)
    ) u_acc (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .clear_i(clear_i),
      .upd_i  (upd[t]),
      .lat_i  (lat),
      .field_i(rd_addr_i[field_w_lp-1:0]),
      .data_o (acc_rd[t])
    );
  end
  assign acc_rd[3] = '0;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_q        <= '0;
      outstanding_q <= '0;
      orphan_q      <= 1'b0;
      dup_q         <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      pend_q        <= pend_d;
      outstanding_q <= outstanding_d;
      orphan_q      <= orphan_d;
      dup_q         <= dup_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign rd_data_o     = rd_data_q;
  assign outstanding_o = outstanding_q;
  assign orphan_o      = orphan_q;
  assign dup_o         = dup_q;

endmodule

// File: tb/tb_remote_load_latency_monitor.sv
// Directed bench for remote_load_latency_monitor; a second, 4-bit-stat instance covers saturation.
module tb_remote_load_latency_monitor;

`ifdef REMOTE_LOAD_MONITOR_HISTOGRAM_EN
  localparam logic [63:0] hb = 64'd1;
`else
  localparam logic [63:0] hb = 64'd0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        launch_v_i, return_v_i, return_yumi_i;
  logic [1:0]  launch_type_i, return_type_i;
  logic [4:0]  launch_reg_id_i, return_reg_id_i;
  logic [31:0] global_ctr_i;
  logic        stat_en_i, clear_i, rd_v_i;
  logic [5:0]  rd_addr_i;
  logic [31:0] rd_data_o;
  logic [6:0]  outstanding_o;
  logic        orphan_o, dup_o;
  logic [3:0]  rd_data2;
  logic [6:0]  outstanding2;
  logic        orphan2, dup2;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk_i = ~clk_i;

  remote_load_latency_monitor dut (
    .clk_i(clk_i), .reset_i(reset_i), .launch_v_i(launch_v_i), .launch_type_i(launch_type_i),
    .launch_reg_id_i(launch_reg_id_i), .return_v_i(return_v_i), .return_yumi_i(return_yumi_i),
    .return_type_i(return_type_i), .return_reg_id_i(return_reg_id_i), .global_ctr_i(global_ctr_i),
    .stat_en_i(stat_en_i), .clear_i(clear_i), .rd_v_i(rd_v_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o), .outstanding_o(outstanding_o), .orphan_o(orphan_o), .dup_o(dup_o)
  );

  remote_load_latency_monitor #(.stat_width_p(4)) dut2 (
    .clk_i(clk_i), .reset_i(reset_i), .launch_v_i(launch_v_i), .launch_type_i(launch_type_i),
    .launch_reg_id_i(launch_reg_id_i), .return_v_i(return_v_i), .return_yumi_i(return_yumi_i),
    .return_type_i(return_type_i), .return_reg_id_i(return_reg_id_i), .global_ctr_i(global_ctr_i),
    .stat_en_i(stat_en_i), .clear_i(clear_i), .rd_v_i(rd_v_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data2), .outstanding_o(outstanding2), .orphan_o(orphan2), .dup_o(dup2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cyc(input bit lv, input logic [1:0] lt, input logic [4:0] lr,
                     input bit rv, input logic [1:0] rt, input logic [4:0] rr,
                     input logic [31:0] ctr);
    launch_v_i = lv; launch_type_i = lt; launch_reg_id_i = lr;
    return_v_i = rv; return_yumi_i = rv; return_type_i = rt; return_reg_id_i = rr;
    global_ctr_i = ctr;
    step();
    launch_v_i = 1'b0; return_v_i = 1'b0; return_yumi_i = 1'b0;
  endtask

  task automatic lau(input logic [1:0] t, input logic [4:0] r, input logic [31:0] ctr);
    cyc(1'b1, t, r, 1'b0, 2'd0, 5'd0, ctr);
  endtask

  task automatic ret(input logic [1:0] t, input logic [4:0] r, input logic [31:0] ctr);
    cyc(1'b0, 2'd0, 5'd0, 1'b1, t, r, ctr);
  endtask

  task automatic rd(input logic [1:0] t, input logic [3:0] f);
    rd_addr_i = {t, f};
    rd_v_i = 1'b1;
    step();
    rd_v_i = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] t, input logic [3:0] f,
                        input logic [63:0] exp);
    rd(t, f);
    check(tag, 64'(rd_data_o), exp);
  endtask

  initial begin
    reset_i = 1'b1;
    launch_v_i = 0; return_v_i = 0; return_yumi_i = 0;
    launch_type_i = 0; return_type_i = 0; launch_reg_id_i = 0; return_reg_id_i = 0;
    global_ctr_i = 0; stat_en_i = 1'b1; clear_i = 1'b0; rd_v_i = 1'b0; rd_addr_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_outstanding", 64'(outstanding_o), 64'd0);
    check("rst_orphan", 64'(orphan_o), 64'd0);
    check("rst_dup", 64'(dup_o), 64'd0);
    check("rst_rd_data", 64'(rd_data_o), 64'd0);
    reset_i = 1'b0;
    step();

    // async reset with loads pending and stats populated
    lau(2'd0, 5'd7, 32'd0);
    ret(2'd0, 5'd7, 32'd4);
    lau(2'd0, 5'd1, 32'd5);
    lau(2'd1, 5'd2, 32'd6);
    lau(2'd2, 5'd0, 32'd7);
    check("pend3_outstanding", 64'(outstanding_o), 64'd3);
    #2 reset_i = 1'b1;
    #1 check("async_rst_outstanding", 64'(outstanding_o), 64'd0);
    step();
    reset_i = 1'b0;
    chk_rd("rst_int_count", 2'd0, 4'd0, 64'd0);
    chk_rd("rst_int_min", 2'd0, 4'd2, 64'hFFFF_FFFF);
    check("rst_int_min_w4", 64'(rd_data2), 64'hF);

    // int reg 5: 100 -> 137
    lau(2'd0, 5'd5, 32'd100);
    ret(2'd0, 5'd5, 32'd137);
    chk_rd("int_count", 2'd0, 4'd0, 64'd1);
    chk_rd("int_sum", 2'd0, 4'd1, 64'd37);
    check("int_sum_sat_w4", 64'(rd_data2), 64'hF);
    chk_rd("int_min", 2'd0, 4'd2, 64'd37);
    chk_rd("int_max", 2'd0, 4'd3, 64'd37);
    chk_rd("int_bin4", 2'd0, 4'd8, hb);

    // float across counter wrap
    lau(2'd1, 5'd3, 32'hFFFF_FFF0);
    ret(2'd1, 5'd3, 32'h10);
    chk_rd("flt_count", 2'd1, 4'd0, 64'd1);
    chk_rd("flt_sum_wrap", 2'd1, 4'd1, 64'd32);
    chk_rd("flt_bin4", 2'd1, 4'd8, hb);
    chk_rd("int_count_untouched", 2'd0, 4'd0, 64'd1);

    // same-slot return+relaunch uses old start
    lau(2'd0, 5'd5, 32'd5);
    lau(2'd2, 5'd0, 32'd10);
    cyc(1'b1, 2'd0, 5'd5, 1'b1, 2'd0, 5'd5, 32'd50);
    check("relaunch_outstanding", 64'(outstanding_o), 64'd2);
    check("relaunch_dup", 64'(dup_o), 64'd0);
    chk_rd("relaunch_count", 2'd0, 4'd0, 64'd2);
    chk_rd("relaunch_sum", 2'd0, 4'd1, 64'd82);
    chk_rd("relaunch_max", 2'd0, 4'd3, 64'd45);
    ret(2'd0, 5'd5, 32'd53);
    chk_rd("new_start_min", 2'd0, 4'd2, 64'd3);
    chk_rd("int_bin0", 2'd0, 4'd4, hb);
    ret(2'd2, 5'd0, 32'd20);
    chk_rd("ic_sum", 2'd2, 4'd1, 64'd10);
    chk_rd("ic_bin1", 2'd2, 4'd5, hb);
    check("drain_outstanding", 64'(outstanding_o), 64'd0);

    // orphan, dup, clear (clear beats a same-cycle update)
    ret(2'd0, 5'd9, 32'd60);
    check("orphan_set", 64'(orphan_o), 64'd1);
    chk_rd("orphan_count", 2'd0, 4'd0, 64'd3);
    lau(2'd0, 5'd2, 32'd100);
    lau(2'd0, 5'd2, 32'd200);
    check("dup_set", 64'(dup_o), 64'd1);
    check("dup_outstanding", 64'(outstanding_o), 64'd1);
    ret(2'd0, 5'd2, 32'd210);
    chk_rd("dup_sum", 2'd0, 4'd1, 64'd95);
    lau(2'd0, 5'd4, 32'd0);
    clear_i = 1'b1;
    ret(2'd0, 5'd4, 32'd7);
    clear_i = 1'b0;
    check("clr_orphan", 64'(orphan_o), 64'd0);
    check("clr_dup", 64'(dup_o), 64'd0);
    check("clr_outstanding", 64'(outstanding_o), 64'd0);
    chk_rd("clr_int_count", 2'd0, 4'd0, 64'd0);
    chk_rd("clr_int_min", 2'd0, 4'd2, 64'hFFFF_FFFF);
    chk_rd("clr_flt_count", 2'd1, 4'd0, 64'd0);

    // stats frozen; valid without yumi is not an event
    stat_en_i = 1'b0;
    lau(2'd0, 5'd6, 32'd0);
    return_v_i = 1'b1; return_yumi_i = 1'b0; return_type_i = 2'd0; return_reg_id_i = 5'd6;
    step();
    return_v_i = 1'b0;
    check("noyumi_outstanding", 64'(outstanding_o), 64'd1);
    ret(2'd0, 5'd6, 32'd5);
    stat_en_i = 1'b1;
    check("frozen_outstanding", 64'(outstanding_o), 64'd0);
    chk_rd("frozen_count", 2'd0, 4'd0, 64'd0);

    // large latency clamps into the last bin
    lau(2'd0, 5'd1, 32'd0);
    ret(2'd0, 5'd1, 32'd1000);
    chk_rd("bin7_clamp", 2'd0, 4'd11, hb);
    chk_rd("oob_field", 2'd0, 4'd12, 64'd0);
    chk_rd("type3_read", 2'd3, 4'd0, 64'd0);
    chk_rd("max_1000", 2'd0, 4'd3, 64'd1000);
    step();
    step();
    check("rd_hold", 64'(rd_data_o), 64'd1000);
    lau(2'd3, 5'd0, 32'd0);
    check("type3_launch", 64'(outstanding_o), 64'd0);
    ret(2'd3, 5'd0, 32'd1);
    check("type3_return", 64'(orphan_o), 64'd0);

    // different slots same cycle
    lau(2'd0, 5'd0, 32'd0);
    cyc(1'b1, 2'd1, 5'd7, 1'b1, 2'd0, 5'd0, 32'd4);
    check("diff_slot_outstanding", 64'(outstanding_o), 64'd1);
    chk_rd("diff_slot_count", 2'd0, 4'd0, 64'd2);
    ret(2'd1, 5'd7, 32'd10);
    chk_rd("diff_slot_flt_sum", 2'd1, 4'd1, 64'd6);

    // saturation of the 4-bit instance
    for (int i = 0; i < 16; i++) begin
      lau(2'd0, 5'd0, 32'd0);
      ret(2'd0, 5'd0, 32'd1);
    end
    chk_rd("count_18", 2'd0, 4'd0, 64'd18);
    check("count_sat_w4", 64'(rd_data2), 64'hF);
    chk_rd("sum_1020", 2'd0, 4'd1, 64'd1020);
    check("sum_sat_w4", 64'(rd_data2), 64'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
